// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector: compares the most recent cfg_len
// sampled bits against a programmable right-aligned pattern and pulses on a match.
module seq_detector_param #(
  parameter int                 PAT_W   = 8,
  parameter int                 LEN_W   = $clog2(PAT_W + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(4'b1001),
  parameter logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4),
  parameter logic               DEF_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             i,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;
  logic [PAT_W-1:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;
  logic             match;

  assign hist_next = {hist_reg[PAT_W-2:0], i};
  assign fill_next = (fill_reg >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill_reg + 1'b1;

  // Only the low len bits of history and pattern take part in the comparison.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  assign match = !cfg_err && (fill_next >= len_reg) &&
                 (((hist_next ^ pat_reg) & len_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg     <= DEF_PAT;
      len_reg     <= DEF_LEN;
      ovl_reg     <= DEF_OVL;
      hist_reg    <= '0;
      fill_reg    <= '0;
      out         <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else if (cfg_load) begin
      // A load discards any bit presented in the same cycle.
      pat_reg  <= cfg_pattern;
      len_reg  <= cfg_len;
      ovl_reg  <= cfg_overlap;
      hist_reg <= '0;
      fill_reg <= '0;
      out      <= 1'b0;
      cfg_err  <= (cfg_len == '0) || (cfg_len > LEN_W'(PAT_W));
    end else if (in_valid) begin
      hist_reg <= hist_next;
      out      <= match;
      if (match) begin
        if (match_count != '1)
          match_count <= match_count + 1'b1;
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        fill_reg <= ovl_reg ? fill_next : '0;
      end else begin
        fill_reg <= fill_next;
      end
    end else begin
      out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized streams checked
// against a queue-based model; a second instance with a 2-bit counter covers saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       i = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       out, cfg_err, out2, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  // Model state: sampled bits since the last clear, bits since the last restart point.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_err, exp_out;
  bit         q[$];
  int         m_fresh, m_cnt, m_cnt2;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i(i), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i(i), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] got();
    return {out, out2, match_count, match_count2, cfg_err & cfg_err2};
  endfunction

  function automatic logic [12:0] want();
    return {exp_out, exp_out, 8'(m_cnt), 2'(m_cnt2), m_err};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    m_pat = 8'b1001; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
    q.delete(); m_fresh = 0; m_cnt = 0; m_cnt2 = 0; exp_out = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = 1'b1; i = 1'($urandom);
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
    m_pat = pat; m_len = int'(len); m_ovl = ovl; m_err = (len == 0) || (len > 8);
    q.delete(); m_fresh = 0; exp_out = 1'b0;
  endtask

  task automatic drive(input bit v, input bit b);
    bit hit;
    in_valid = v; i = b; cfg_load = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hit = 1'b0;
    if (v) begin
      q.push_back(b);
      if (q.size() > 16) void'(q.pop_front());
      m_fresh++;
      if (!m_err && m_fresh >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) m_fresh = 0;
      end
    end
    exp_out = hit;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b1; in_valid = 1'b1; i = 1'b1;
    do_reset();
    checks++;
    if (got() !== 13'd0) begin
      errors++;
      $display("FAIL reset: got %b required %b", got(), 13'd0);
    end
  endtask

  task automatic test_overlap_default();
    bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      drive(1'b1, s[n]);
      checks++;
      if (got() !== want() || out !== (n == 3 || n == 6)) begin
        errors++;
        $display("FAIL overlap bit%0d: got %b required %b", n, got(), want());
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL overlap count: got %0d required 2", match_count);
    end
  endtask

  task automatic test_nonoverlap();
    bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
    do_reset();
    load(8'b1001, 4'd4, 1'b0);
    for (int n = 0; n < 7; n++) begin
      drive(1'b1, s[n]);
      checks++;
      if (got() !== want() || out !== (n == 3)) begin
        errors++;
        $display("FAIL nonoverlap bit%0d: got %b required %b", n, got(), want());
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL nonoverlap count: got %0d required 1", match_count);
    end
  endtask

  task automatic test_gap();
    bit v[7] = '{1, 1, 0, 0, 0, 1, 1};
    bit s[7] = '{1, 0, 1, 1, 1, 0, 1};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      drive(v[n], s[n]);
      checks++;
      if (got() !== want() || out !== (n == 6)) begin
        errors++;
        $display("FAIL gap cyc%0d: got %b required %b", n, got(), want());
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (out !== 1'b0 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL gap after: got out=%b cnt=%0d required out=0 cnt=1", out, match_count);
    end
  endtask

  task automatic test_midstream_load();
    do_reset();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    load(8'b111, 4'd3, 1'b1);
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (got() !== want() || out !== (n >= 2)) begin
        errors++;
        $display("FAIL midload bit%0d: got %b required %b", n, got(), want());
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load(8'b111, 4'd3, 1'b1);
    for (int n = 0; n < 7; n++) drive(1'b1, 1'b1);
    checks++;
    if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
      errors++;
      $display("FAIL saturation: got cnt2=%0d cnt=%0d required cnt2=3 cnt=5",
               match_count2, match_count);
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad[2] = '{4'd0, 4'd9};
    do_reset();
    for (int b = 0; b < 2; b++) begin
      load(8'h00, bad[b], 1'($urandom));
      for (int n = 0; n < 20; n++) begin
        drive(1'b1, 1'($urandom));
        checks++;
        if (got() !== want() || out !== 1'b0 || cfg_err !== 1'b1) begin
          errors++;
          $display("FAIL cfg_err len%0d cyc%0d: got %b required %b", bad[b], n, got(), want());
        end
      end
    end
    // Reset while a load and a valid bit are both presented restores defaults.
    rst = 1'b1; cfg_load = 1'b1; cfg_len = 4'd0; in_valid = 1'b1;
    do_reset();
    checks++;
    if (got() !== 13'd0) begin
      errors++;
      $display("FAIL rst midstream: got %b required %b", got(), 13'd0);
    end
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    checks++;
    if (out !== 1'b1 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL rst defaults: got out=%b cnt=%0d required out=1 cnt=1", out, match_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] len;
    do_reset();
    for (int r = 0; r < 25; r++) begin
      len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      load(8'($urandom), len, 1'($urandom));
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL random load r%0d: got %b required %b", r, got(), want());
      end
      for (int n = 0; n < 60; n++) begin
        drive($urandom_range(0, 3) != 0, 1'($urandom));
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL random r%0d cyc%0d: got %b required %b", r, n, got(), want());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_default();
    test_nonoverlap();
    test_gap();
    test_midstream_load();
    test_saturation();
    test_cfg_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
